// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder with carry, time-shared across all digits.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b - BCD digits; ci - decimal carry-in; s - BCD sum digit; co - decimal carry-out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (raw > {1'b0, BCD_MAX}) begin
      // Skip the six unused binary codes; the overflow bit becomes the carry.
      s  = raw[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = raw[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add / subtract, one digit per cycle, lowest digit first.
// Latency: done pulses in the (DIGITS+1)th cycle counting the start-sampling edge's cycle as cycle 1.
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped, not queued.
// Ports: clk, rst_n (async active-low); start/mode/cin/a/b request; busy, done, s, cout, err results.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [W-1:0]    b_nines;
  logic            bad_digit;
  logic [3:0]      dig_s;
  logic            dig_co;

  // Operands are shifted right each RUN cycle, so the adder always sees digit 0.
  bcd_digit_add u_digit (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // Raw-operand validity and nine's complement of b, both from the live inputs
  // so they line up with the acceptance edge.
  always_comb begin
    bad_digit = 1'b0;
    b_nines   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
      b_nines[4*i +: 4] = BCD_MAX - b[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction as a + (nine's complement of b) + 1.
          b_d     = (mode == MODE_SUB) ? b_nines : b;
          carry_d = (mode == MODE_SUB) ? 1'b1 : cin;
          idx_d   = '0;
          err_d   = bad_digit;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
        s_d     = (s_q >> 4) | (W'(dig_s) << (W - 4));
        carry_d = dig_co;
        if (idx_q == IW'(DIGITS - 1)) begin
          cout_d  = dig_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int LAT    = DIGITS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, err;
  logic [15:0] s;

  int nvec = 0;
  int nerr = 0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    bit          chk_s;
    logic [15:0] exp_s;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal-arithmetic reference: legal digits only.
  task automatic ref_op(input logic m, input logic ci, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] rs, output logic rc);
    int va = bcd2int(x);
    int vb = bcd2int(y);
    int r;
    if (m) begin
      r  = va - vb;
      rc = (va >= vb);
      rs = int2bcd((r + 10000) % 10000);
    end else begin
      r  = va + vb + int'(ci);
      rc = (r >= 10000);
      rs = int2bcd(r % 10000);
    end
  endtask

  // Drives a one-cycle start; returns #1 after the sampling edge (cycle 1).
  task automatic launch(input logic m, input logic ci, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1; mode = m; cin = ci; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs while running; they must be ignored.
    mode = 1'($urandom); cin = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", 32'(n), 32'(LAT));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    logic [15:0] held;
    launch(v.mode, v.cin, v.a, v.b);
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    wait_done(1, n);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    if (v.chk_s) begin
      chk({tag, "_s"}, 32'(s), 32'(v.exp_s));
      chk({tag, "_cout"}, 32'(cout), 32'(v.exp_cout));
    end
    held = s;
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_s_hold"}, 32'(s), 32'(held));
  endtask

  vec_t tbl[10];

  initial begin
    int n, cnt;
    vec_t v;
    logic [15:0] es;
    logic ec;

    //        mode cin a        b        chk  exp_s    cout err
    tbl[0] = '{1'b0, 1'b0, 16'h0999, 16'h0001, 1'b1, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h9999, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h4567, 16'h5432, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h1000, 16'h0001, 1'b1, 16'h0999, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'h00A5, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1};

    // Reset state.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First start on the first rising edge after reset release.
    for (int i = 0; i < 10; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Randomized legal operands against the decimal model.
    for (int i = 0; i < 30; i++) begin
      v.mode = 1'($urandom);
      v.cin  = 1'($urandom);
      for (int d = 0; d < 4; d++) begin
        v.a[4*d +: 4] = 4'($urandom_range(0, 9));
        v.b[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      ref_op(v.mode, v.cin, v.a, v.b, es, ec);
      v.chk_s = 1'b1; v.exp_s = es; v.exp_cout = ec; v.exp_err = 1'b0;
      run_vec($sformatf("rnd%0d", i), v);
    end

    // start re-pulsed in RUN cycle 2 is dropped.
    launch(1'b0, 1'b0, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    start = 1'b1; a = 16'h9999; b = 16'h9999;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, n);
    chk("restart_latency", 32'(n), 32'(LAT));
    chk("restart_s", 32'(s), 32'h3333);
    count_dones(10, cnt);
    chk("restart_extra_done", 32'(cnt), 32'd0);

    // Reset in RUN cycle 3 aborts immediately.
    launch(1'b0, 1'b0, 16'h1234, 16'h4321);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(10, cnt);
    chk("abort_no_done", 32'(cnt), 32'd0);
    v = '{1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5555, 1'b0, 1'b0};
    run_vec("after_abort", v);

    // start held high: next op accepted in the first IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; cin = 1'b0; a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    a = 16'h0002; b = 16'h0003;
    wait_done(1, n);
    chk("hold_first_latency", 32'(n), 32'(LAT));
    chk("hold_first_s", 32'(s), 32'h0010);
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("hold_accept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1, n);
    chk("hold_second_latency", 32'(n), 32'(LAT));
    chk("hold_second_s", 32'(s), 32'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits per operand; legal range 1..16.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1: asynchronous active-low reset.
REQ-004 Port start  input  1: request pulse; sampled only in IDLE.
REQ-005 Port mode  input  1: 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 Port cin  input  1: decimal carry-in for add; ignored in subtract; sampled with start.
REQ-007 Port a  input  4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
REQ-008 Port b  input  4*DIGITS: operand B, packed BCD, same packing.
REQ-009 Port busy  output  1: high while an operation is in progress.
REQ-010 Port done  output  1: one-cycle pulse when result is valid.
REQ-011 Port s  output  4*DIGITS: packed BCD result.
REQ-012 Port cout  output  1: add: decimal carry-out; subtract: 1 = no borrow (a >= b).
REQ-013 Port err  output  1: at least one operand digit above 9 at the start sample.

Function
REQ-014 FSM states IDLE, RUN, DONE; no other reachable state.
REQ-015 IDLE with start=1: latch a, b, mode, cin; clear digit index; busy=1 next cycle; go to RUN.
REQ-016 Subtract latch: b digits replaced by nine's complement (9 - digit); initial carry = 1. Add: initial carry = cin.
REQ-017 RUN: one digit per cycle, lowest first. Raw = a_i + b_i + carry (5 bits). If raw > 9: digit = raw + 6 (low 4 bits), carry = 1; else digit = raw, carry = 0.
REQ-018 RUN lasts exactly DIGITS cycles, then goes to DONE; index stops at DIGITS-1, with no wrap.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle; s and cout present final values; return to IDLE.
REQ-020 Latency: done is asserted DIGITS+1 cycles after the start sampling edge.
REQ-021 s, cout and err hold their values from DONE until the next start is accepted. They are not cleared on return to IDLE.
REQ-022 start asserted in RUN or DONE is ignored and is not queued. Operand changes in RUN have no effect.
REQ-023 start held high continuously: a new operation is accepted in the first IDLE cycle after DONE.
REQ-024 Subtract with a < b: s = ten's complement of (b - a) modulo 10^DIGITS; cout = 0.
REQ-025 err is computed from the latched raw a and b digits, not the complemented b, and updates at acceptance. The computation proceeds per REQ-017 and the result is undefined but deterministic.
REQ-026 Add overflow: s = (a + b + cin) mod 10^DIGITS, cout = 1.

Reset
REQ-027 rst_n low, asynchronous: state = IDLE, busy = 0, done = 0, s = 0, cout = 0, err = 0, index = 0, latched operands = 0.
REQ-028 Reset asserted during RUN or DONE aborts the operation; no done pulse follows deassertion.
REQ-029 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package bcd_pkg holds: the FSM state enum, BCD_MAX = 9, BCD_CORR = 6, and MODE_ADD/MODE_SUB constants.
REQ-031 One combinational sub-module bcd_digit_add (a 4-bit input, b 4-bit input, ci 1-bit input; s 4-bit output, co 1-bit output) implements REQ-017. It is instantiated once and time-shared across digits.
REQ-032 The operand and result registers are shift registers or index-addressed registers. No per-digit adder replication is allowed.

Verification (DIGITS=4)
REQ-033 Add, a=0999, b=0001, cin=0 -> done after 5 cycles; s=1000, cout=0, err=0.
REQ-034 Add, a=9999, b=0001, cin=0 -> s=0000, cout=1; add a=4567, b=5432, cin=1 -> s=0000, cout=1.
REQ-035 Sub, a=1000, b=0001 -> s=0999, cout=1; sub a=0001, b=0002 -> s=9999, cout=0.
REQ-036 Add, a=00A5, b=0001 -> err=1 at done; done still pulses at 5 cycles.
REQ-037 start re-pulsed in RUN cycle 2 -> ignored: single done, result of the first operands.
REQ-038 rst_n low during RUN cycle 3 -> all outputs 0 immediately; no done after release; next start yields a correct result.
